// File: rtl/s2p_aligner_multilane_pkg.sv
// ============================================================================
// Module      : s2p_aligner_multilane_pkg
// Description : Shared lane state encoding and default alignment symbol.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package s2p_aligner_multilane_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } lane_state_e;

    localparam logic [7:0] DEFAULT_COMMA = 8'hBC;

endpackage

`default_nettype wire

// File: rtl/s2p_aligner_multilane_lane.sv
// ============================================================================
// Module      : s2p_aligner_multilane_lane
// Description : One serial lane: MSB-first deserialiser with comma word lock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module s2p_aligner_multilane_lane
    import s2p_aligner_multilane_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] COMMA       = WIDTH'(DEFAULT_COMMA),
    parameter int               LOCK_COMMAS = 2
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             ENB,
    input  logic             s_in,
    output logic [WIDTH-1:0] p_out,
    output logic             p_valid,
    output logic             p_comma,
    output logic             locked
);

    localparam int             BW             = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int             CW             = $clog2(LOCK_COMMAS + 1);
    localparam logic [BW-1:0]  c_last_bit     = BW'(WIDTH - 1);
    localparam logic [CW-1:0]  c_lock_target  = CW'(LOCK_COMMAS);

    lane_state_e      state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]    comma_cnt_q, comma_cnt_d;
    logic             valid_q, valid_d;
    logic             is_comma_q, is_comma_d;
    logic             locked_q, locked_d;

    logic [WIDTH-1:0] w_nxt;
    logic             w_boundary;
    logic             w_nxt_comma;
    logic [CW-1:0]    w_cnt_inc;

    assign w_nxt       = {shift_q[WIDTH-2:0], s_in};
    assign w_boundary  = (bit_cnt_q == c_last_bit);
    assign w_nxt_comma = (w_nxt == COMMA);
    assign w_cnt_inc   = comma_cnt_q + CW'(1);

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        word_d      = word_q;
        bit_cnt_d   = bit_cnt_q;
        comma_cnt_d = comma_cnt_q;
        valid_d     = 1'b0;
        is_comma_d  = 1'b0;
        locked_d    = locked_q;

        if (!ENB) begin
            // Disabled: drop lock but keep the shift register and last word.
            state_d     = SEARCH;
            bit_cnt_d   = '0;
            comma_cnt_d = '0;
            locked_d    = 1'b0;
        end else begin
            shift_d   = w_nxt;
            bit_cnt_d = w_boundary ? '0 : bit_cnt_q + BW'(1);
            case (state_q)
                SEARCH: begin
                    if (w_nxt_comma) begin
                        bit_cnt_d   = '0;
                        comma_cnt_d = CW'(1);
                        if (LOCK_COMMAS == 1) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end else begin
                            state_d = ALIGN;
                        end
                    end
                end
                ALIGN: begin
                    if (w_boundary) begin
                        if (w_nxt_comma) begin
                            comma_cnt_d = w_cnt_inc;
                            if (w_cnt_inc == c_lock_target) begin
                                state_d  = LOCKED;
                                locked_d = 1'b1;
                            end
                        end else begin
                            state_d     = SEARCH;
                            comma_cnt_d = '0;
                        end
                    end
                end
                LOCKED: begin
                    if (w_boundary) begin
                        word_d     = w_nxt;
                        valid_d    = 1'b1;
                        is_comma_d = w_nxt_comma;
                    end
                end
                default: begin
                    state_d = SEARCH;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q     <= SEARCH;
            shift_q     <= '0;
            word_q      <= '0;
            bit_cnt_q   <= '0;
            comma_cnt_q <= '0;
            valid_q     <= 1'b0;
            is_comma_q  <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            word_q      <= word_d;
            bit_cnt_q   <= bit_cnt_d;
            comma_cnt_q <= comma_cnt_d;
            valid_q     <= valid_d;
            is_comma_q  <= is_comma_d;
            locked_q    <= locked_d;
        end
    end

    assign p_out   = word_q;
    assign p_valid = valid_q;
    assign p_comma = is_comma_q;
    assign locked  = locked_q;

endmodule

`default_nettype wire

// File: rtl/s2p_aligner_multilane.sv
// ============================================================================
// Module      : s2p_aligner_multilane
// Description : LANES independent comma-aligned serial-to-parallel lanes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module s2p_aligner_multilane
    import s2p_aligner_multilane_pkg::*;
#(
    parameter int               LANES       = 4,
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] COMMA       = WIDTH'(DEFAULT_COMMA),
    parameter int               LOCK_COMMAS = 2
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   ENB,
    input  logic [LANES-1:0]       s_in,
    output logic [LANES*WIDTH-1:0] p_out,
    output logic [LANES-1:0]       p_valid,
    output logic [LANES-1:0]       p_comma,
    output logic [LANES-1:0]       locked,
    output logic                   all_locked
);

    // Lane skew is deliberately not corrected; each lane strobes on its own boundary.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        s2p_aligner_multilane_lane #(
            .WIDTH       (WIDTH),
            .COMMA       (COMMA),
            .LOCK_COMMAS (LOCK_COMMAS)
        ) u_lane (
            .CLK     (CLK),
            .reset   (reset),
            .ENB     (ENB),
            .s_in    (s_in[k]),
            .p_out   (p_out[k*WIDTH +: WIDTH]),
            .p_valid (p_valid[k]),
            .p_comma (p_comma[k]),
            .locked  (locked[k])
        );
    end

    assign all_locked = &locked;

endmodule

`default_nettype wire

// File: tb/tb_s2p_aligner_multilane.sv
// ============================================================================
// Module      : tb_s2p_aligner_multilane
// Description : Self-checking bench: per-lane bit queues, strobe scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_s2p_aligner_multilane;

    localparam int LANES = 4;
    localparam int WIDTH = 8;

    logic                   CLK = 1'b0;
    logic                   reset;
    logic                   ENB;
    logic [LANES-1:0]       s_in;
    logic [LANES*WIDTH-1:0] p_out;
    logic [LANES-1:0]       p_valid;
    logic [LANES-1:0]       p_comma;
    logic [LANES-1:0]       locked;
    logic                   all_locked;

    always #5 CLK = ~CLK;

    s2p_aligner_multilane #(
        .LANES       (LANES),
        .WIDTH       (WIDTH),
        .COMMA       (8'hBC),
        .LOCK_COMMAS (2)
    ) dut (
        .CLK        (CLK),
        .reset      (reset),
        .ENB        (ENB),
        .s_in       (s_in),
        .p_out      (p_out),
        .p_valid    (p_valid),
        .p_comma    (p_comma),
        .locked     (locked),
        .all_locked (all_locked)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    bit         bit_q [LANES][$];
    logic [8:0] exp_q [LANES][$];

    typedef struct {
        int              lane;
        int              junk;
        logic [3:0][7:0] w;
        logic [3:0]      emit;
        bit              exp_lock;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_word(input int lane, input logic [7:0] w, input bit emit);
        for (int b = 7; b >= 0; b--) bit_q[lane].push_back(w[b]);
        if (emit) exp_q[lane].push_back({(w == 8'hBC), w});
    endtask

    task automatic push_zeros(input int lane, input int n);
        for (int i = 0; i < n; i++) bit_q[lane].push_back(1'b0);
    endtask

    task automatic step();
        for (int k = 0; k < LANES; k++)
            s_in[k] = (bit_q[k].size() > 0) ? bit_q[k].pop_front() : 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic flush();
        ENB = 1'b0;
        step();
        ENB = 1'b1;
        steps(8);
    endtask

    function automatic vec_t mk(input int lane, input int junk,
                                input logic [7:0] w0, input logic [7:0] w1,
                                input logic [7:0] w2, input logic [7:0] w3,
                                input logic [3:0] emit, input bit lk);
        vec_t v;
        v.lane     = lane;
        v.junk     = junk;
        v.w        = {w3, w2, w1, w0};
        v.emit     = emit;
        v.exp_lock = lk;
        return v;
    endfunction

    // Scoreboard: every strobe must match the oldest expected word of its lane.
    initial begin
        forever begin
            @(negedge CLK);
            for (int k = 0; k < LANES; k++) begin
                if (p_valid[k] === 1'b1) begin
                    if (exp_q[k].size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_strobe lane%0d: got word 0x%0h, want no strobe",
                                 k, p_out[k*WIDTH +: WIDTH]);
                    end else begin
                        check($sformatf("strobe_lane%0d", k),
                              {23'd0, p_comma[k], p_out[k*WIDTH +: WIDTH]},
                              {23'd0, exp_q[k].pop_front()});
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        ENB   = 1'b0;
        s_in  = '0;

        // Reset held with random activity: everything stays cleared.
        for (int i = 0; i < 16; i++) begin
            s_in = LANES'($urandom);
            ENB  = 1'($urandom);
            @(posedge CLK);
            #1;
            check("rst_hold_p_out", p_out, 32'd0);
            check("rst_hold_flags", {19'd0, p_valid, p_comma, locked, all_locked}, 32'd0);
        end
        s_in  = '0;
        ENB   = 1'b1;
        reset = 1'b1;

        // Lane 0: junk 101, BC, BC, 55, BC.
        bit_q[0].push_back(1'b1);
        bit_q[0].push_back(1'b0);
        bit_q[0].push_back(1'b1);
        push_word(0, 8'hBC, 1'b0);
        push_word(0, 8'hBC, 1'b0);
        steps(18);
        check("t2_locked_before", {31'd0, locked[0]}, 32'd0);
        step();
        check("t2_locked_edge", {31'd0, locked[0]}, 32'd1);
        push_word(0, 8'h55, 1'b1);
        push_word(0, 8'hBC, 1'b1);
        steps(7);
        check("t2_no_early_valid", {31'd0, p_valid[0]}, 32'd0);
        step();
        check("t2_first_word", {23'd0, p_valid[0], p_out[7:0]}, {23'd0, 1'b1, 8'h55});
        check("t2_first_comma", {31'd0, p_comma[0]}, 32'd0);
        steps(8);
        check("t2_second_word", {22'd0, p_valid[0], p_comma[0], p_out[7:0]},
              {22'd0, 1'b1, 1'b1, 8'hBC});

        vecs[0] = mk(1, 0, 8'hBC, 8'h12, 8'h00, 8'h00, 4'b0000, 1'b0);
        vecs[1] = mk(1, 0, 8'hBC, 8'hBC, 8'h12, 8'h34, 4'b1100, 1'b1);
        vecs[2] = mk(2, 5, 8'hBC, 8'hBC, 8'hA5, 8'hBC, 4'b1100, 1'b1);
        vecs[3] = mk(3, 2, 8'h12, 8'hBC, 8'h7E, 8'hBC, 4'b0000, 1'b0);
        vecs[4] = mk(0, 3, 8'hBC, 8'hBC, 8'hBC, 8'h55, 4'b1100, 1'b1);
        for (int i = 0; i < 5; i++) begin
            flush();
            push_zeros(vecs[i].lane, vecs[i].junk);
            for (int j = 0; j < 4; j++)
                push_word(vecs[i].lane, vecs[i].w[j], vecs[i].emit[j]);
            steps(vecs[i].junk + 34);
            check($sformatf("row%0d_locked", i), {31'd0, locked[vecs[i].lane]},
                  {31'd0, vecs[i].exp_lock});
            check($sformatf("row%0d_other_lanes", i),
                  {28'd0, locked & ~(LANES'(1) << vecs[i].lane)}, 32'd0);
            check($sformatf("row%0d_drained", i), exp_q[vecs[i].lane].size(), 32'd0);
        end

        // Skewed lanes: lane k delayed by k bits.
        flush();
        for (int k = 0; k < LANES; k++) begin
            push_zeros(k, k);
            push_word(k, 8'hBC, 1'b0);
            push_word(k, 8'hBC, 1'b0);
            push_word(k, 8'hA5, 1'b1);
        end
        steps(15);
        for (int s = 16; s <= 19; s++) begin
            step();
            check($sformatf("skew_locked_s%0d", s), {28'd0, locked},
                  {28'd0, LANES'((1 << (s - 15)) - 1)});
            check($sformatf("skew_all_locked_s%0d", s), {31'd0, all_locked},
                  {31'd0, (s == 19)});
        end
        steps(9);
        for (int k = 0; k < LANES; k++)
            check($sformatf("skew_drained_lane%0d", k), exp_q[k].size(), 32'd0);

        // Asynchronous reset mid-word while locked.
        check("pre_reset_all_locked", {31'd0, all_locked}, 32'd1);
        check("pre_reset_p_out", p_out, 32'hA5A5A5A5);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_p_out", p_out, 32'd0);
        check("async_rst_flags", {19'd0, p_valid, p_comma, locked, all_locked}, 32'd0);
        step();
        #2;
        reset = 1'b1;
        steps(30);
        check("post_reset_locked", {28'd0, locked}, 32'd0);

        // One-cycle ENB drop loses lock; a single comma is not enough to relock.
        push_word(0, 8'hBC, 1'b0);
        push_word(0, 8'hBC, 1'b0);
        push_word(0, 8'h55, 1'b1);
        steps(26);
        check("t6_locked", {31'd0, locked[0]}, 32'd1);
        ENB = 1'b0;
        step();
        ENB = 1'b1;
        check("t6_enb_drop_locked", {28'd0, locked}, 32'd0);
        check("t6_enb_p_out_hold", {24'd0, p_out[7:0]}, 32'h55);
        check("t6_enb_valid", {28'd0, p_valid}, 32'd0);
        push_zeros(0, 8);
        push_word(0, 8'hBC, 1'b0);
        push_zeros(0, 8);
        steps(24);
        check("t6_single_comma", {31'd0, locked[0]}, 32'd0);
        push_word(0, 8'hBC, 1'b0);
        push_word(0, 8'hBC, 1'b0);
        steps(15);
        check("t6_relock_before", {31'd0, locked[0]}, 32'd0);
        step();
        check("t6_relock", {31'd0, locked[0]}, 32'd1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
